// File: rtl/fpu_ss_pkg.sv
// Shared types and constants for the FPU subsystem writeback path.
package fpu_ss_pkg;

  localparam int unsigned XIdWidth    = 4;
  localparam int unsigned HartIdWidth = 2;

  // Tag travelling with every FPU operation through fpnew.
  typedef struct packed {
    logic [4:0]             addr;
    logic                   rd_is_fp;
    logic [XIdWidth-1:0]    id;
    logic [HartIdWidth-1:0] core_id;
  } fpu_tag_t;

  // Metadata returned with every load/store response.
  typedef struct packed {
    logic [XIdWidth-1:0]    id;
    logic [4:0]             rd;
    logic                   we;
    logic [HartIdWidth-1:0] core_id;
  } mem_metadata_t;

  // One retired instruction reported back to the core.
  typedef struct packed {
    logic [HartIdWidth-1:0] hartid;
    logic [XIdWidth-1:0]    id;
    logic [31:0]            data;
    logic [4:0]             rd;
    logic                   we;
    logic [2:0]             ecswe;
    logic [5:0]             ecsdata;
    logic                   exc;
    logic [5:0]             exccode;
  } x_result_t;

  // Which producer owns the register-file write port this cycle.
  typedef enum logic [1:0] {WbNone, WbLsu, WbFpu} wb_src_e;

  parameter logic [5:0] EXC_LOAD_ACCESS_FAULT = 6'd5;
  parameter logic [5:0] ECS_FS_DIRTY          = 6'b001100;

  // ecswe bit that tells the core the FP state in mstatus.FS changed.
  localparam logic [2:0] ECS_WE_FS = 3'b010;

endpackage

// File: rtl/fpu_ss_writeback_if.sv
// Bundle of the FPU, LSU, register-file and core-result signals of the writeback stage.
interface fpu_ss_writeback_if;
  import fpu_ss_pkg::*;

  logic          fpu_out_valid_i;
  logic          fpu_out_ready_o;
  logic [31:0]   fpu_result_i;
  fpu_tag_t      fpu_tag_i;
  logic [4:0]    fpu_status_i;
  logic          lsu_valid_i;
  mem_metadata_t lsu_meta_i;
  logic [31:0]   lsu_rdata_i;
  logic          lsu_err_i;
  logic          fpr_we_o;
  logic [4:0]    fpr_waddr_o;
  logic [31:0]   fpr_wdata_o;
  logic          fflags_we_o;
  logic [4:0]    fflags_o;
  logic          x_result_valid_o;
  logic          x_result_ready_i;
  x_result_t     x_result_o;
  logic          overflow_o;
  logic          busy_o;

  // Writeback stage side.
  modport slave (
    input  fpu_out_valid_i, fpu_result_i, fpu_tag_i, fpu_status_i,
    input  lsu_valid_i, lsu_meta_i, lsu_rdata_i, lsu_err_i,
    input  x_result_ready_i,
    output fpu_out_ready_o, fpr_we_o, fpr_waddr_o, fpr_wdata_o,
    output fflags_we_o, fflags_o, x_result_valid_o, x_result_o,
    output overflow_o, busy_o
  );

  // Surrounding subsystem side.
  modport master (
    output fpu_out_valid_i, fpu_result_i, fpu_tag_i, fpu_status_i,
    output lsu_valid_i, lsu_meta_i, lsu_rdata_i, lsu_err_i,
    output x_result_ready_i,
    input  fpu_out_ready_o, fpr_we_o, fpr_waddr_o, fpr_wdata_o,
    input  fflags_we_o, fflags_o, x_result_valid_o, x_result_o,
    input  overflow_o, busy_o
  );

endinterface

// File: rtl/fpu_ss_result_fifo.sv
// In-order FIFO of results toward the core; push and pop may coincide even when full.
module fpu_ss_result_fifo
  import fpu_ss_pkg::*;
#(
  parameter int unsigned  Depth = 4,
  localparam int unsigned CntW  = $clog2(Depth + 1)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            push_i,
  input  x_result_t       data_i,
  input  logic            pop_i,
  output x_result_t       data_o,
  output logic            valid_o,
  output logic [CntW-1:0] count_o
);

  localparam int unsigned     PtrW    = $clog2(Depth);
  localparam logic [PtrW-1:0] LastPtr = PtrW'(Depth - 1);
  localparam logic [CntW-1:0] FullCnt = CntW'(Depth);

  x_result_t       mem [Depth];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q;
  logic            do_push, do_pop;

  function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] p);
    return (p == LastPtr) ? '0 : p + 1'b1;
  endfunction

  // A pop frees the slot in the same cycle, so a full FIFO still takes a push alongside it.
  assign do_pop  = pop_i && (count_q != '0);
  assign do_push = push_i && ((count_q != FullCnt) || do_pop);

  // Entry storage.
  // NOTE: the data array has no reset; valid entries are tracked by count_q and the output is masked when empty.
  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr_q] <= data_i;
  end

  // Pointers and occupancy.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= next_ptr(wr_ptr_q);
      if (do_pop)  rd_ptr_q <= next_ptr(rd_ptr_q);
      if (do_push && !do_pop)      count_q <= count_q + CntW'(1);
      else if (do_pop && !do_push) count_q <= count_q - CntW'(1);
    end
  end

  assign valid_o = (count_q != '0);
  assign data_o  = valid_o ? mem[rd_ptr_q] : '0;
  assign count_o = count_q;

endmodule

// File: rtl/fpu_ss_writeback.sv
// FPU subsystem writeback: arbitrates the FP register-file write port between
// unstallable load responses and FPU results, accumulates fflags and queues
// one result per retired instruction toward the core.
module fpu_ss_writeback
  import fpu_ss_pkg::*;
#(
  parameter int unsigned ResultDepth = 4
) (
  input logic               clk_i,
  input logic               rst_ni,
  fpu_ss_writeback_if.slave bus
);

  localparam int unsigned     CntW     = $clog2(ResultDepth + 1);
  localparam logic [CntW-1:0] FullCnt  = CntW'(ResultDepth);
  // FPU may only go while at least two slots are free: one for itself, one kept for a load.
  localparam logic [CntW-1:0] StallCnt = CntW'(ResultDepth - 1);

  wb_src_e         src;
  logic [CntW-1:0] count;
  logic            fifo_valid, fifo_pop, fpu_acc;
  logic            fpr_wr, ff_wr, ovf_set;
  logic [4:0]      fpr_addr, ff_val;
  logic [31:0]     fpr_data;
  x_result_t       push_res;

  logic            fpr_we_q, fflags_we_q, overflow_q;
  logic [4:0]      fpr_waddr_q, fflags_q;
  logic [31:0]     fpr_wdata_q;

  assign bus.fpu_out_ready_o = rst_ni && !bus.lsu_valid_i && (count < StallCnt);
  assign fpu_acc  = bus.fpu_out_valid_i && bus.fpu_out_ready_o;
  assign fifo_pop = fifo_valid && bus.x_result_ready_i;

  // Loads win the port unconditionally; the FPU only when it was granted.
  always_comb begin
    src = WbNone;
    if (bus.lsu_valid_i) src = WbLsu;
    else if (fpu_acc)    src = WbFpu;
  end

  // Build the register write and the core result for the accepted producer.
  // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    push_res = '0;
    fpr_wr   = 1'b0;
    fpr_addr = '0;
    fpr_data = '0;
    ff_wr    = 1'b0;
    ff_val   = '0;
    unique case (src)
      WbLsu: begin
        fpr_wr           = bus.lsu_meta_i.we && !bus.lsu_err_i;
        fpr_addr         = bus.lsu_meta_i.rd;
        fpr_data         = bus.lsu_rdata_i;
        push_res.hartid  = bus.lsu_meta_i.core_id;
        push_res.id      = bus.lsu_meta_i.id;
        push_res.rd      = bus.lsu_meta_i.rd;
        push_res.exc     = bus.lsu_err_i;
        push_res.exccode = bus.lsu_err_i ? EXC_LOAD_ACCESS_FAULT : '0;
      end
      WbFpu: begin
        fpr_wr          = bus.fpu_tag_i.rd_is_fp;
        fpr_addr        = bus.fpu_tag_i.addr;
        fpr_data        = bus.fpu_result_i;
        push_res.hartid = bus.fpu_tag_i.core_id;
        push_res.id     = bus.fpu_tag_i.id;
        push_res.rd     = bus.fpu_tag_i.addr;
        push_res.we     = !bus.fpu_tag_i.rd_is_fp;
        push_res.data   = bus.fpu_tag_i.rd_is_fp ? '0 : bus.fpu_result_i;
        ff_wr           = |bus.fpu_status_i;
        ff_val          = bus.fpu_status_i;
      end
      default: ;
    endcase
    if (fpr_wr) begin
      push_res.ecswe   = ECS_WE_FS;
      push_res.ecsdata = ECS_FS_DIRTY;
    end else begin
      fpr_addr = '0;
      fpr_data = '0;
    end
  end

  // A load arriving at a full FIFO with nothing leaving loses its result entry.
  assign ovf_set = (src == WbLsu) && (count == FullCnt) && !fifo_pop;

  // Register-file write port and fflags pulse, one cycle after acceptance.
  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      fpr_we_q    <= 1'b0;
      fpr_waddr_q <= '0;
      fpr_wdata_q <= '0;
      fflags_we_q <= 1'b0;
      fflags_q    <= '0;
    end else begin
      fpr_we_q    <= fpr_wr;
      fpr_waddr_q <= fpr_addr;
      fpr_wdata_q <= fpr_data;
      fflags_we_q <= ff_wr;
      fflags_q    <= ff_val;
    end
  end

  // Sticky overflow flag, cleared only by reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)      overflow_q <= 1'b0;
    else if (ovf_set) overflow_q <= 1'b1;
  end

  fpu_ss_result_fifo #(
    .Depth (ResultDepth)
  ) u_result_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (src != WbNone),
    .data_i  (push_res),
    .pop_i   (fifo_pop),
    .data_o  (bus.x_result_o),
    .valid_o (fifo_valid),
    .count_o (count)
  );

  assign bus.x_result_valid_o = fifo_valid;
  assign bus.fpr_we_o         = fpr_we_q;
  assign bus.fpr_waddr_o      = fpr_waddr_q;
  assign bus.fpr_wdata_o      = fpr_wdata_q;
  assign bus.fflags_we_o      = fflags_we_q;
  assign bus.fflags_o         = fflags_q;
  assign bus.overflow_o       = overflow_q;
  assign bus.busy_o           = fifo_valid || fpr_we_q;

endmodule

// File: tb/tb_fpu_ss_writeback.sv
// Scoreboard bench for fpu_ss_writeback: the driver pushes expected results and
// register writes from a behavioural model, a monitor compares every cycle.
module tb_fpu_ss_writeback;
  import fpu_ss_pkg::*;

  localparam int DEPTH = 4;

  logic clk_i;
  logic rst_ni;

  fpu_ss_writeback_if bus ();

  fpu_ss_writeback #(.ResultDepth(DEPTH)) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state: exp_q mirrors the FIFO contents toward the core.
  x_result_t   exp_q[$];
  bit          pend_push, pend_fpr_we, pend_ff_we, pend_ovf;
  x_result_t   pend_res;
  logic [4:0]  pend_waddr, pend_ff;
  logic [31:0] pend_wdata;
  bit          exp_fpr_we, exp_ff_we, exp_ovf, exp_ready;
  logic [4:0]  exp_waddr, exp_ff;
  logic [31:0] exp_wdata;

  // The FPU operation currently offered (held until accepted).
  bit          fpu_have;
  fpu_tag_t    fpu_tag;
  logic [31:0] fpu_res;
  logic [4:0]  fpu_st;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic x_result_t lsu_expect(input mem_metadata_t m, input bit err);
    x_result_t r = '0;
    r.hartid = m.core_id;
    r.id     = m.id;
    r.rd     = m.rd;
    r.exc    = err;
    r.exccode = err ? 6'd5 : 6'd0;
    if (m.we && !err) begin
      r.ecswe   = 3'b010;
      r.ecsdata = 6'b001100;
    end
    return r;
  endfunction

  function automatic x_result_t fpu_expect(input fpu_tag_t t, input logic [31:0] d);
    x_result_t r = '0;
    r.hartid = t.core_id;
    r.id     = t.id;
    r.rd     = t.addr;
    if (t.rd_is_fp) begin
      r.ecswe   = 3'b010;
      r.ecsdata = 6'b001100;
    end else begin
      r.we   = 1'b1;
      r.data = d;
    end
    return r;
  endfunction

  task automatic new_fpu_op();
    fpu_have = 1'b1;
    fpu_tag  = fpu_tag_t'($urandom);
    fpu_res  = $urandom;
    fpu_st   = ($urandom_range(1) == 1) ? 5'($urandom) : 5'd0;
  endtask

  task automatic clear_model();
    exp_q.delete();
    pend_push = 0; pend_fpr_we = 0; pend_ff_we = 0; pend_ovf = 0;
    exp_fpr_we = 0; exp_ff_we = 0; exp_ovf = 0; exp_ready = 0;
    fpu_have = 0;
  endtask

  task automatic drive_idle();
    bus.fpu_out_valid_i  = 1'b0;
    bus.fpu_result_i     = '0;
    bus.fpu_tag_i        = '0;
    bus.fpu_status_i     = '0;
    bus.lsu_valid_i      = 1'b0;
    bus.lsu_meta_i       = '0;
    bus.lsu_rdata_i      = '0;
    bus.lsu_err_i        = 1'b0;
    bus.x_result_ready_i = 1'b0;
  endtask

  // One clock: commit last cycle's predictions, then drive and predict this cycle.
  task automatic step(input bit lsu_v, input mem_metadata_t meta, input logic [31:0] rdata,
                      input bit err, input bit rready, input int fpu_pct);
    int size;
    bit pop;
    @(posedge clk_i);
    if (pend_push) exp_q.push_back(pend_res);
    exp_fpr_we = pend_fpr_we; exp_waddr = pend_waddr; exp_wdata = pend_wdata;
    exp_ff_we  = pend_ff_we;  exp_ff    = pend_ff;
    exp_ovf    = exp_ovf | pend_ovf;
    pend_push = 0; pend_fpr_we = 0; pend_ff_we = 0; pend_ovf = 0;
    #1;
    if (!fpu_have && ($urandom_range(99) < fpu_pct)) new_fpu_op();
    bus.fpu_out_valid_i  = fpu_have;
    bus.fpu_tag_i        = fpu_tag;
    bus.fpu_result_i     = fpu_res;
    bus.fpu_status_i     = fpu_st;
    bus.lsu_valid_i      = lsu_v;
    bus.lsu_meta_i       = meta;
    bus.lsu_rdata_i      = rdata;
    bus.lsu_err_i        = err;
    bus.x_result_ready_i = rready;
    size = exp_q.size();
    pop  = (size != 0) && rready;
    exp_ready = !lsu_v && ((DEPTH - size) >= 2);
    if (lsu_v) begin
      pend_res    = lsu_expect(meta, err);
      pend_push   = !((size == DEPTH) && !pop);
      pend_ovf    = !pend_push;
      pend_fpr_we = meta.we && !err;
      pend_waddr  = meta.rd;
      pend_wdata  = rdata;
    end else if (fpu_have && exp_ready) begin
      pend_res    = fpu_expect(fpu_tag, fpu_res);
      pend_push   = 1;
      pend_fpr_we = fpu_tag.rd_is_fp;
      pend_waddr  = fpu_tag.addr;
      pend_wdata  = fpu_res;
      pend_ff_we  = (fpu_st != 0);
      pend_ff     = fpu_st;
      fpu_have    = 0;
    end
  endtask

  task automatic rand_step(input int lsu_pct, input int rdy_pct, input int fpu_pct, input int err_pct);
    step($urandom_range(99) < lsu_pct, mem_metadata_t'($urandom), $urandom,
         $urandom_range(99) < err_pct, $urandom_range(99) < rdy_pct, fpu_pct);
  endtask

  task automatic idle_step(input bit rready);
    step(1'b0, '0, '0, 1'b0, rready, 0);
  endtask

  // Monitor: compares every DUT output once per cycle, popping the scoreboard on handshakes.
  initial begin
    forever begin
      @(negedge clk_i);
      if (rst_ni) begin
        check("fpu_out_ready", 64'(bus.fpu_out_ready_o), 64'(exp_ready));
        check("fpr_we", 64'(bus.fpr_we_o), 64'(exp_fpr_we));
        if (exp_fpr_we) begin
          check("fpr_waddr", 64'(bus.fpr_waddr_o), 64'(exp_waddr));
          check("fpr_wdata", 64'(bus.fpr_wdata_o), 64'(exp_wdata));
        end
        check("fflags_we", 64'(bus.fflags_we_o), 64'(exp_ff_we));
        if (exp_ff_we) check("fflags", 64'(bus.fflags_o), 64'(exp_ff));
        check("overflow", 64'(bus.overflow_o), 64'(exp_ovf));
        check("busy", 64'(bus.busy_o), 64'((exp_q.size() != 0) || exp_fpr_we));
        check("x_result_valid", 64'(bus.x_result_valid_o), 64'(exp_q.size() != 0));
        if (bus.x_result_valid_o && (exp_q.size() != 0)) begin
          check("x_result", 64'(bus.x_result_o), 64'(exp_q[0]));
          if (bus.x_result_ready_i) void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_fpu_out_ready"}, 64'(bus.fpu_out_ready_o), 64'd0);
    check({tag, "_fpr_we"}, 64'(bus.fpr_we_o), 64'd0);
    check({tag, "_fpr_waddr"}, 64'(bus.fpr_waddr_o), 64'd0);
    check({tag, "_fpr_wdata"}, 64'(bus.fpr_wdata_o), 64'd0);
    check({tag, "_fflags_we"}, 64'(bus.fflags_we_o), 64'd0);
    check({tag, "_fflags"}, 64'(bus.fflags_o), 64'd0);
    check({tag, "_x_result_valid"}, 64'(bus.x_result_valid_o), 64'd0);
    check({tag, "_x_result"}, 64'(bus.x_result_o), 64'd0);
    check({tag, "_overflow"}, 64'(bus.overflow_o), 64'd0);
    check({tag, "_busy"}, 64'(bus.busy_o), 64'd0);
  endtask

  initial begin
    mem_metadata_t m;
    clear_model();
    drive_idle();
    rst_ni = 1'b0;
    repeat (3) @(negedge clk_i);
    check_all_zero("reset");
    #2 rst_ni = 1'b1;

    // FP-destination FPU op with inexact flag.
    fpu_have = 1; fpu_tag = '{addr: 5'd5, rd_is_fp: 1'b1, id: 4'd1, core_id: 2'd0};
    fpu_res = 32'h3F80_0000; fpu_st = 5'b00001;
    idle_step(1'b1);
    idle_step(1'b1);

    // Integer-destination FPU op (feq).
    fpu_have = 1; fpu_tag = '{addr: 5'd10, rd_is_fp: 1'b0, id: 4'd2, core_id: 2'd1};
    fpu_res = 32'd1; fpu_st = 5'd0;
    idle_step(1'b1);
    idle_step(1'b1);

    // Collision: load and FPU in the same cycle, FPU follows one cycle later.
    fpu_have = 1; fpu_tag = '{addr: 5'd12, rd_is_fp: 1'b1, id: 4'd3, core_id: 2'd0};
    fpu_res = 32'h4000_0000; fpu_st = 5'b10000;
    m = '{id: 4'd4, rd: 5'd7, we: 1'b1, core_id: 2'd0};
    step(1'b1, m, 32'hCAFE_F00D, 1'b0, 1'b1, 0);
    idle_step(1'b1);
    idle_step(1'b1);

    // Load with bus error.
    m = '{id: 4'd5, rd: 5'd3, we: 1'b1, core_id: 2'd2};
    step(1'b1, m, 32'hDEAD_BEEF, 1'b1, 1'b1, 0);
    idle_step(1'b1);

    // Random mixed traffic.
    for (int i = 0; i < 1500; i++) rand_step(30, 70, 60, 10);
    repeat (10) idle_step(1'b1);

    // Backpressure: FPU stalls at three entries, a load fills, the next overflows.
    repeat (5) step(1'b0, '0, '0, 1'b0, 1'b0, 100);
    m = '{id: 4'd6, rd: 5'd8, we: 1'b1, core_id: 2'd0};
    step(1'b1, m, 32'h1234_5678, 1'b0, 1'b0, 100);
    m = '{id: 4'd7, rd: 5'd9, we: 1'b1, core_id: 2'd0};
    step(1'b1, m, 32'h8765_4321, 1'b0, 1'b0, 100);
    repeat (3) idle_step(1'b0);
    check("overflow_set", 64'(bus.overflow_o), 64'd1);
    repeat (10) idle_step(1'b1);
    for (int i = 0; i < 300; i++) rand_step(30, 60, 60, 10);
    repeat (10) idle_step(1'b1);
    fpu_have = 0;

    // Reset with three entries queued and an FPR write pending.
    fpu_have = 1; fpu_tag = '{addr: 5'd1, rd_is_fp: 1'b1, id: 4'd8, core_id: 2'd0};
    fpu_res = 32'h1111_1111; fpu_st = 5'd0;
    idle_step(1'b0);
    fpu_have = 1; fpu_tag = '{addr: 5'd2, rd_is_fp: 1'b0, id: 4'd9, core_id: 2'd0};
    fpu_res = 32'h2222_2222;
    idle_step(1'b0);
    m = '{id: 4'd10, rd: 5'd4, we: 1'b1, core_id: 2'd0};
    step(1'b1, m, 32'h3333_3333, 1'b0, 1'b0, 0);
    @(posedge clk_i);
    #1 drive_idle();
    #1;
    check("prereset_fpr_we", 64'(bus.fpr_we_o), 64'd1);
    check("prereset_valid", 64'(bus.x_result_valid_o), 64'd1);
    #1 rst_ni = 1'b0;
    #1 check_all_zero("midreset");
    clear_model();
    repeat (2) @(negedge clk_i);
    #2 rst_ni = 1'b1;
    for (int i = 0; i < 200; i++) rand_step(30, 70, 60, 10);
    repeat (10) idle_step(1'b1);

    @(negedge clk_i);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fpu_ss_writeback.md
# fpu_ss_writeback

Writeback stage of the FPU subsystem, directly downstream of the FPU core (fpnew, tagged with `fpu_tag_t`) and the load path (`mem_metadata_t` plus `x_mem_result`). It arbitrates the single FP register-file write port between load data and FPU results, and accumulates FPU exception flags. It queues one `x_result_t` per retired instruction toward the core over the cv-x-if result handshake.

## Interface
Parameters:
- `ResultDepth`, default 4: entries in the result FIFO toward the core; minimum 2.

Ports. Clock is `clk_i`; reset is `rst_ni`, asynchronous and active-low.
- `clk_i` in 1: clock
- `rst_ni` in 1: asynchronous active-low reset
- `fpu_out_valid_i` in 1: FPU result valid
- `fpu_out_ready_o` out 1: FPU result accepted this cycle when high with valid
- `fpu_result_i` in 32: FPU result data
- `fpu_tag_i` in `fpu_tag_t`: destination address, `rd_is_fp`, id, core_id
- `fpu_status_i` in 5: fpnew status flags (NV, DZ, OF, UF, NX)
- `lsu_valid_i` in 1: load or store response; cannot be stalled
- `lsu_meta_i` in `mem_metadata_t`: id, rd, we, core_id of the responding access
- `lsu_rdata_i` in 32: load data
- `lsu_err_i` in 1: bus error on the access
- `fpr_we_o` out 1: FP regfile write enable
- `fpr_waddr_o` out 5: FP regfile write address
- `fpr_wdata_o` out 32: FP regfile write data
- `fflags_we_o` out 1: pulse to OR `fflags_o` into fcsr.fflags
- `fflags_o` out 5: flags to accumulate
- `x_result_valid_o` out 1: result valid toward core
- `x_result_ready_i` in 1: core accepts result
- `x_result_o` out `x_result_t`: result toward core
- `overflow_o` out 1: sticky error, an LSU response arrived with the FIFO full
- `busy_o` out 1: FIFO non-empty or FPR write pending

## Operation
- **Acceptance:**
  - An LSU response is taken whenever `lsu_valid_i` is high.
  - `fpu_out_ready_o` = `!lsu_valid_i && free >= 2`, where `free` = `ResultDepth - count`. This reserves one slot for an unstallable load.
- **LSU accepted:**
  - FPR write happens when `lsu_meta_i.we && !lsu_err_i`: address = `lsu_meta_i.rd`, data = `lsu_rdata_i`.
  - A result is pushed with `we=0`, `rd` = meta rd, `data=0`, `exc` = `lsu_err_i`, and `exccode` = `EXC_LOAD_ACCESS_FAULT` (6'd5) if err, else 0.
  - Stores (meta `we=0`) push a result and perform no FPR write.
- **FPU accepted:**
  - If `rd_is_fp`, write the FPR at `tag.addr` with `fpu_result_i`, and push a result with `we=0`.
  - Otherwise push a result with `we=1`, `rd=tag.addr`, `data=fpu_result_i`, and perform no FPR write.
  - `fflags_we_o` pulses with `fflags_o=fpu_status_i` when the status is nonzero.
- `id` comes from the accepted tag/meta. `ecswe` is 3'b010 when the FPR is written, else 0. `ecsdata` = 6'b001100 (FS dirty) when written, else 0.
- **FIFO:** in order, push at tail, pop on `x_result_valid_o && x_result_ready_i`. Push and pop in the same cycle is legal even when full.
- **Overflow:** an LSU push while `count==ResultDepth` with no pop sets `overflow_o`. The entry is dropped, and the FPR write still occurs. Only reset clears `overflow_o`.

## Timing
- FPR write port is registered: `fpr_we_o`/`fpr_waddr_o`/`fpr_wdata_o` assert exactly 1 cycle after acceptance, for 1 cycle.
- `fflags_we_o`/`fflags_o` are registered and aligned with the FPR write.
- A pushed result is visible on `x_result_valid_o` at the earliest 1 cycle after acceptance (no bypass).
- `x_result_o` holds stable while valid and not ready.
- Back-to-back acceptance is allowed, at one per cycle; there is no bubble between LSU and FPU.
- **Reset (async assert, sync deassert external):**
  - All outputs go to 0, FIFO empty, `overflow_o`=0.
  - An in-flight FPR write is discarded.
  - `fpu_out_ready_o` is 0 during reset.
- `fpu_out_ready_o` is combinational from `lsu_valid_i` and registered `count`. It never depends on `fpu_out_valid_i`.

## Structure
- **Package additions to `fpu_ss_pkg`:**
  - `typedef enum logic [1:0] {WbNone, WbLsu, WbFpu} wb_src_e`
  - `parameter logic [5:0] EXC_LOAD_ACCESS_FAULT = 6'd5`
  - `parameter logic [5:0] ECS_FS_DIRTY = 6'b001100`
- **Sub-module `fpu_ss_result_fifo`:** parameterised FIFO of `x_result_t` (depth, count output, simultaneous push/pop when full). The top holds the arbiter, the FPR write register and the fflags register.

## Test plan
- **FP-destination FPU op:** `fpu_tag_i.addr=5`, `rd_is_fp=1`, result 32'h3F800000, status 5'b00001 → next cycle `fpr_we_o`=1 with addr 5 and data 3F800000, `fflags_we_o`=1 with `fflags_o`=00001. The result has `we`=0 and `ecswe`=010.
- **Integer-destination FPU op (feq):** `rd_is_fp=0`, addr 10, result 1 → no FPR write. The result has `we`=1, `rd`=10, `data`=1, `ecswe`=0.
- **Collision:** `lsu_valid_i` and `fpu_out_valid_i` both high → `fpu_out_ready_o`=0. The load writes the FPR next cycle, and the FPU is accepted the following cycle. Core results arrive in the order LSU then FPU.
- **Load bus error:** `lsu_err_i`=1, meta rd 3 → no FPR write. The result has `exc`=1 and `exccode`=5.
- **Backpressure:** `x_result_ready_i`=0 with `ResultDepth`=4; FPU stalls once `count`=3. An LSU push then fills the FIFO to 4 with no overflow. A further LSU response sets `overflow_o`, which stays set until reset.
- **Reset mid-operation:** assert `rst_ni` low with 3 entries queued and an FPR write pending → all outputs 0 immediately and the FIFO empty after release.
